// File: rtl/motor_pwm_gen.sv
// PWM generator for a motor bridge: prescaled 255-step period, boundary-aligned
// ratio/direction updates, and a dead period on direction reversal.
module motor_pwm_gen #(
    parameter int PRESCALE = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pwm_enable,
    input  logic       pwm_update,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_direction,
    input  logic [7:0] dir_deadtime,
    output logic       pwm_done,
    output logic       pwm_signal,
    output logic       pwm_dir_out,
    output logic [7:0] active_ratio,
    output logic       pwm_busy
);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    state_t     state_reg, state_next;
    logic [7:0] presc_reg, presc_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [7:0] ratio_reg, ratio_next;
    logic [7:0] pend_ratio_reg, pend_ratio_next;
    logic [7:0] dead_cnt_reg, dead_cnt_next;
    logic       pending_reg, pending_next;
    logic       pend_dir_reg, pend_dir_next;
    logic       dir_reg, dir_next;
    logic       signal_reg, signal_next;
    logic       done_reg, done_next;
    logic       tick;
    logic       boundary;

    assign tick     = (state_reg != IDLE) && pwm_enable && (presc_reg == PRESC_LAST);
    assign boundary = tick && (cnt_reg == 8'd254);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            presc_reg      <= 8'd0;
            cnt_reg        <= 8'd0;
            ratio_reg      <= 8'd0;
            pend_ratio_reg <= 8'd0;
            dead_cnt_reg   <= 8'd0;
            pending_reg    <= 1'b0;
            pend_dir_reg   <= 1'b0;
            dir_reg        <= 1'b0;
            signal_reg     <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            presc_reg      <= presc_next;
            cnt_reg        <= cnt_next;
            ratio_reg      <= ratio_next;
            pend_ratio_reg <= pend_ratio_next;
            dead_cnt_reg   <= dead_cnt_next;
            pending_reg    <= pending_next;
            pend_dir_reg   <= pend_dir_next;
            dir_reg        <= dir_next;
            signal_reg     <= signal_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        presc_next      = presc_reg;
        cnt_next        = cnt_reg;
        ratio_next      = ratio_reg;
        pend_ratio_next = pend_ratio_reg;
        dead_cnt_next   = dead_cnt_reg;
        pending_next    = pending_reg;
        pend_dir_next   = pend_dir_reg;
        dir_next        = dir_reg;
        signal_next     = 1'b0;
        done_next       = 1'b0;

        if (!pwm_enable) begin
            // Direction output is deliberately held so the bridge does not glitch.
            state_next    = IDLE;
            presc_next    = 8'd0;
            cnt_next      = 8'd0;
            ratio_next    = 8'd0;
            pending_next  = 1'b0;
            dead_cnt_next = 8'd0;
        end else begin
            case (state_reg)
                IDLE: state_next = RUN;
                RUN, DEAD: begin
                    signal_next = (cnt_reg < ratio_reg);
                    presc_next  = tick ? 8'd0 : presc_reg + 8'd1;
                    if (tick)
                        cnt_next = boundary ? 8'd0 : cnt_reg + 8'd1;
                    if (boundary) begin
                        if (state_reg == RUN) begin
                            if (pending_reg) begin
                                if ((pend_dir_reg == dir_reg) || (dir_deadtime == 8'd0)) begin
                                    dir_next     = pend_dir_reg;
                                    ratio_next   = pend_ratio_reg;
                                    pending_next = 1'b0;
                                    done_next    = 1'b1;
                                end else begin
                                    state_next    = DEAD;
                                    ratio_next    = 8'd0;
                                    dead_cnt_next = dir_deadtime;
                                end
                            end
                        end else if (dead_cnt_reg <= 8'd1) begin
                            state_next    = RUN;
                            dead_cnt_next = 8'd0;
                            dir_next      = pend_dir_reg;
                            ratio_next    = pend_ratio_reg;
                            pending_next  = 1'b0;
                            done_next     = 1'b1;
                        end else begin
                            dead_cnt_next = dead_cnt_reg - 8'd1;
                        end
                    end
                    // Capture after the boundary decision so a coincident request waits a period.
                    if (pwm_update) begin
                        pend_ratio_next = pwm_ratio;
                        pend_dir_next   = pwm_direction;
                        pending_next    = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign pwm_done     = done_reg;
    assign pwm_signal   = signal_reg;
    assign pwm_dir_out  = dir_reg;
    assign active_ratio = ratio_reg;
    assign pwm_busy     = pending_reg || (state_reg == DEAD);

endmodule

// File: doc/motor_pwm_gen.md
MOTOR_PWM_GEN -- requirements
Module: motor_pwm_gen

Interface
REQ-001 SHALL have parameter PRESCALE, default 4: clocks per PWM tick, legal range 1..255.
REQ-002 SHALL have port clock  input  1  main clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pwm_enable  input  1  runs the generator when high.
REQ-005 SHALL have port pwm_update  input  1  single-cycle request to load pwm_ratio/pwm_direction.
REQ-006 SHALL have port pwm_ratio  input  8  requested high time, in ticks out of 255.
REQ-007 SHALL have port pwm_direction  input  1  requested motor direction.
REQ-008 SHALL have port dir_deadtime  input  8  PWM periods held low on a direction reversal.
REQ-009 SHALL have port pwm_done  output  1  one-cycle pulse when a request takes effect.
REQ-010 SHALL have port pwm_signal  output  1  PWM drive to the motor bridge.
REQ-011 SHALL have port pwm_dir_out  output  1  applied direction to the motor bridge.
REQ-012 SHALL have port active_ratio  output  8  ratio currently applied.
REQ-013 SHALL have port pwm_busy  output  1  high while a request is pending or the block is in DEAD.

Function
REQ-014 SHALL use a prescaler counting 0..PRESCALE-1; tick = prescaler at PRESCALE-1 while enabled.
REQ-015 SHALL use an 8-bit period counter cnt, 0..254, incremented per tick; boundary = tick with cnt==254, after which cnt wraps to 0.
REQ-016 SHALL register pwm_signal to (cnt < active_ratio) with one clock of latency, so ratio 0 gives 0% and ratio 255 gives 100% high.
REQ-017 SHALL implement states IDLE, RUN and DEAD.
REQ-018 SHALL enter IDLE whenever pwm_enable is low: prescaler=0, cnt=0, active_ratio=0, pending cleared, pwm_signal=0 next cycle, pwm_dir_out held; pwm_update ignored, no pwm_done.
REQ-019 SHALL move IDLE->RUN on the first cycle pwm_enable is high, with cnt starting at 0.
REQ-020 SHALL, on pwm_update in RUN or DEAD, capture pwm_ratio/pwm_direction into pending registers and set the pending flag; a later update overwrites pending, and only the last value is applied (one pwm_done).
REQ-021 SHALL treat a pwm_update coincident with a boundary as captured, to be applied at the following boundary.
REQ-022 SHALL, at a boundary in RUN with pending set and pend_dir==pwm_dir_out, load active_ratio<=pend_ratio, clear pending and pulse pwm_done in the same cycle.
REQ-023 SHALL, at a boundary in RUN with pending set, pend_dir!=pwm_dir_out and dir_deadtime==0, load pwm_dir_out, load active_ratio, clear pending and pulse pwm_done in that same cycle.
REQ-024 SHALL, at a boundary in RUN with pending set, pend_dir!=pwm_dir_out and dir_deadtime!=0, enter DEAD with active_ratio<=0 and dead_cnt<=dir_deadtime (latched).
REQ-025 SHALL, at each boundary in DEAD, decrement dead_cnt; at the boundary where dead_cnt==1, load pwm_dir_out<=pend_dir and active_ratio<=pend_ratio, clear pending, pulse pwm_done and return to RUN.
REQ-026 SHALL, in DEAD, keep pending/pend_dir updatable per REQ-020, with the final pend_dir applied on exit even if it equals the prior direction.
REQ-027 SHALL guarantee that pwm_signal is never high in the period a new pwm_dir_out value is applied when dir_deadtime!=0.
REQ-028 SHALL hold pwm_done high for exactly one clock per applied request, never while pwm_enable is low.

Reset
REQ-029 SHALL, on reset_n low, immediately set state=IDLE, prescaler=0, cnt=0, pending=0, dead_cnt=0, pwm_signal=0, pwm_dir_out=0, active_ratio=0, pwm_done=0, pwm_busy=0, including mid-period and mid-DEAD.
REQ-030 SHALL, after reset release, need no pwm_update before running at ratio 0.

Verification (PRESCALE=1)
REQ-031 SHALL be verified by: enable, update ratio=100 dir=0 -> pwm_done at first boundary (cycle ~255), then 100 high/155 low clocks per 255-clock period.
REQ-032 SHALL be verified by: ratio 0 then ratio 255 -> pwm_signal constantly low, then constantly high across periods.
REQ-033 SHALL be verified by: running 128 dir=0, update 128 dir=1, dir_deadtime=2 -> two full periods of pwm_signal=0, then pwm_dir_out=1, pwm_done pulse, 128/255 duty.
REQ-034 SHALL be verified by: three updates (10, 20, 30) within one period -> a single pwm_done, active_ratio=30.
REQ-035 SHALL be verified by: update on a boundary cycle -> applied one period later; pwm_enable dropped mid-DEAD -> pwm_signal=0, pwm_busy=0, no pwm_done.
REQ-036 SHALL be verified by: reset_n asserted mid-period with active_ratio=200 -> all outputs at reset values before the next clock edge.
